demo_vga_core: RTL

DEMO_VGA_CORE -- requirements
Module: demo_vga_core

---
 rtl/demo_vga_core.sv | 105 ++++++++++
 1 files changed

// File: rtl/demo_vga_core.sv
// demo_vga_core: VGA raster timing generator with four frame-latched test patterns
module demo_vga_core #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CBITS     = 2,
    parameter bit SYNC_POL  = 1'b0,
    parameter int FRAME_W   = 8,
    parameter int BAR_SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [1:0]           mode,
    output logic [3*CBITS-1:0]   rgb,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 de,
    output logic                 frame_start,
    output logic [FRAME_W-1:0]   frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW0 = HW > VW ? HW : VW;
    localparam int AW = AW0 > 6 ? AW0 : 6;
    localparam int CW = 3 * CBITS;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [1:0]    mode_q;
    logic          h_last, v_last, wrap, vis;
    logic [AW-1:0] h_ext, v_ext;
    logic [HW-1:0] h_sum;
    logic          chk;
    logic [2:0]    bar;
    logic [CW-1:0] pix;

    assign h_last = hcnt == H_LAST;
    assign v_last = vcnt == V_LAST;
    assign wrap   = h_last && v_last;
    assign vis    = (hcnt < H_VIS) && (vcnt < V_VIS);

    // Pattern generator for the current raster position; frame_cnt is stable across a frame
    always_comb begin
        h_ext = AW'(hcnt);
        v_ext = AW'(vcnt);
        h_sum = hcnt + HW'(frame_cnt);
        chk   = 1'((AW'(h_sum) ^ v_ext) >> 5);
        bar   = 3'(hcnt >> BAR_SHIFT);
        pix   = mode_q == 2'd0 ? {{CBITS{bar[2]}}, {CBITS{bar[1]}}, {CBITS{bar[0]}}} :
                mode_q == 2'd1 ? {CW{chk}} :
                mode_q == 2'd2 ? CW'(h_ext ^ v_ext) + CW'(frame_cnt) :
                frame_cnt[CW-1:0];
    end

    // Raster counters; frame count and pattern mode only change at the end-of-frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt      <= '0;
            vcnt      <= '0;
            frame_cnt <= '0;
            mode_q    <= '0;
        end else if (ena) begin
            hcnt <= h_last ? '0 : hcnt + HW'(1);
            if (h_last)
                vcnt <= v_last ? '0 : vcnt + VW'(1);
            if (wrap) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
                mode_q    <= mode;
            end
        end
    end

    // Registered outputs, all one cycle behind the counters so they stay mutually aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb         <= '0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else if (ena) begin
            de          <= vis;
            rgb         <= vis ? pix : '0;
            hsync       <= (hcnt >= H_SS && hcnt < H_SE) ? SYNC_POL : ~SYNC_POL;
            vsync       <= (vcnt >= V_SS && vcnt < V_SE) ? SYNC_POL : ~SYNC_POL;
            frame_start <= hcnt == '0 && vcnt == '0;
        end
    end
endmodule
